// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
// Other files pull these in with import rr_arbiter4_pkg::*.
package rr_arbiter4_pkg;

  localparam int NUM_REQ      = 4;
  localparam int DEF_MAX_HOLD = 15;
  localparam int DEF_CNT_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } st_t;

  // One-hot (or zero) 4-bit vector to its 2-bit index; zero maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The arbiter also exposes its FSM state and priority pointer for checkers.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  // req is level-sensitive and held until served; done is a one-cycle
  // end-of-transaction strobe from the current owner, looked at only while a
  // grant is held. grant/grant_valid/timeout are all registered outputs.
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               timeout;
  st_t                dbg_state;
  logic [1:0]         dbg_ptr;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  timeout,
    input  dbg_state,
    input  dbg_ptr
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output timeout,
    output dbg_state,
    output dbg_ptr
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit scanning from ptr
// upward with wrap 3->0. Output is one-hot or zero.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] onehot
);

  logic [7:0] req2;
  logic [7:0] sel2;
  logic [3:0] rot;
  logic [3:0] sel;
  logic [2:0] back_base;

  // Rotate so requester ptr lands at bit 0, take the lowest set bit, then
  // rotate the single-bit result back into requester positions.
  always_comb begin
    req2      = {req, req};
    rot       = req2[ptr +: 4];
    sel       = rot & (~rot + 4'd1);
    sel2      = {sel, sel};
    back_base = 3'd4 - {1'b0, ptr};
    onehot    = sel2[back_base +: 4];
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a registered one-hot grant,
// a rotating priority pointer and a hold timer that force-releases a stuck owner.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  st_t                state,    state_nxt;
  logic [1:0]         ptr,      ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] grant_q,  grant_nxt;
  logic               gv_q;
  logic               timeout_q, timeout_nxt;
  logic [NUM_REQ-1:0] pick;
  logic               owner_req;
  logic               at_limit;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick)
  );

  assign owner_req = |(bus.req & grant_q);
  assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Exit checks in BUSY are prioritised: done, then withdrawal, then the
  // hold limit. Only the last one raises timeout, so done on the limit
  // cycle is an ordinary release.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    grant_nxt   = grant_q;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (|bus.req) begin
          grant_nxt = pick;
          hold_nxt  = '0;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.done || !owner_req || at_limit) begin
          grant_nxt   = '0;
          ptr_nxt     = onehot_to_idx(grant_q) + 2'd1;
          hold_nxt    = '0;
          state_nxt   = ST_IDLE;
          timeout_nxt = !bus.done && owner_req && at_limit;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        grant_nxt = '0;
        hold_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      grant_q   <= '0;
      gv_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      grant_q   <= grant_nxt;
      gv_q      <= |grant_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.timeout     = timeout_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_ptr     = ptr;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));
  a_gv_matches:    assert property (@(posedge clk) gv_q == (|grant_q));

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: vector table, hand-written corner sequences and
// randomized traffic, all scored against a behavioural model.
module tb_rr_arbiter4;
  import rr_arbiter4_pkg::*;

  localparam int MAX_HOLD = 15;
  localparam int W        = 6;

  logic clk;
  logic rst;
  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 when nothing granted; held counts cycles the grant has been visible.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_step(input logic r, input logic [3:0] q, input logic d);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held  = 1;
        end
      end
    end else begin
      m_to = 1'b0;
      if (d || !q[m_owner] || m_held >= MAX_HOLD) begin
        m_to    = !d && q[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, |g, m_to};
  endfunction

  // ---------------- driver ----------------
  // Called at the negedge: drive inputs, advance the model, let one posedge
  // happen, then score at the following negedge.
  task automatic cycle(input logic r, input logic [3:0] q, input logic d);
    logic [W-1:0] exp;
    rst      = r;
    bus.req  = q;
    bus.done = d;
    model_step(r, q, d);
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    check("model", 8'({bus.grant, bus.grant_valid, bus.timeout}), 8'(exp));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];
  int   n;
  logic [3:0] rq;
  logic       rd;
  logic       rr;

  initial begin
    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    @(negedge clk);

    // Reset behaviour, strict rotation with done, withdrawal, done-in-IDLE.
    vecs = '{
      '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0},
      '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0},
      '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0},
      '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0},
      '{1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0},
      '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0},
      '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0}
    };
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d_grant", i), 8'(bus.grant), 8'(vecs[i].exp_grant));
      check($sformatf("vec%0d_gv", i), 8'(bus.grant_valid), 8'(|vecs[i].exp_grant));
      check($sformatf("vec%0d_to", i), 8'(bus.timeout), 8'(vecs[i].exp_to));
    end

    // Stuck requester: 15-cycle hold, timeout pulse, immediate re-grant.
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    check("stuck_first", 8'(bus.grant), 8'h04);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (bus.grant == 4'b0100) begin
        cycle(1'b0, 4'b0100, 1'b0);
        if (bus.grant == 4'b0100) n++;
      end
    end
    check("stuck_hold_len", 8'(n), 8'd15);
    check("stuck_to_pulse", 8'(bus.timeout), 8'h01);
    check("stuck_to_gnt", 8'(bus.grant), 8'h00);
    cycle(1'b0, 4'b0100, 1'b0);
    check("stuck_regrant", 8'(bus.grant), 8'h04);
    check("stuck_to_clear", 8'(bus.timeout), 8'h00);

    // done lands on the hold limit: ordinary release, pointer advances.
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    check("lim_grant", 8'(bus.grant), 8'h01);
    repeat (14) cycle(1'b0, 4'b0001, 1'b0);
    check("lim_still", 8'(bus.grant), 8'h01);
    cycle(1'b0, 4'b0001, 1'b1);
    check("lim_rel", 8'(bus.grant), 8'h00);
    check("lim_no_to", 8'(bus.timeout), 8'h00);
    cycle(1'b0, 4'b1111, 1'b0);
    check("lim_ptr_adv", 8'(bus.grant), 8'h02);

    // Reset while granted drops the grant and restores ptr=0.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    check("rst_pre", 8'(bus.grant), 8'h08);
    cycle(1'b1, 4'b1001, 1'b0);
    check("rst_drop", 8'(bus.grant), 8'h00);
    check("rst_no_to", 8'(bus.timeout), 8'h00);
    cycle(1'b0, 4'b1001, 1'b0);
    check("rst_regrant", 8'(bus.grant), 8'h01);

    // Randomized traffic; requests change slowly so timeouts occur too.
    rq = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rq = 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 11) == 0);
      rr = ($urandom_range(0, 299) == 0);
      cycle(rr, rq, rd);
    end

    check("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
